rcc_frame_sched: RTL
====================

# rcc_frame_sched

Frame scheduler that sits between the spectrum (Goertzel) engine and the results character conversion block. It collects the eight 16-bit tone magnitudes of one analysis frame into a fill bank and double-buffers them. It then replays the frame to the converter as nine strobed register writes: eight bins followed by one commit write. After each commit it enforces a programmable hold-off so that a new frame never overwrites the converter's holding registers while the converter is still evaluating the previous one.

## Interface
Parameters:
- GAP_CYCLES, 128: minimum clk cycles in GAP after each commit write. Must be ≥1 and cover the converter's worst-case evaluation time.
- ADDR_COMMIT, 4'hF: address driven on the commit write. Bit 3 must be 1.

Ports:
- clk, in, 1: system clock. All flops are rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- bin_valid, in, 1: upstream bin valid. Upstream holds the bin until it is accepted.
- bin_ready, out, 1: bin accepted on clk edge when bin_valid & bin_ready.
- bin_index, in, 3: bin number, 0=697 Hz … 3=941 Hz, 4=1209 Hz … 7=1633 Hz.
- bin_mag, in, 16: bin magnitude, unsigned.
- bin_last, in, 1: marks the final bin of a frame. Qualified by acceptance.
- rcc_clk, out, 1: converter write strobe. Registered, glitch-free. The converter samples on its falling edge.
- address, out, 4: converter register address. Registered.
- din, out, 16: converter write data. Registered.
- busy, out, 1: 1 when the sender is not in IDLE or a completed frame is pending.
- frame_count, out, 8: number of commit writes issued. Wraps modulo 256.

## Operation
- Fill bank F[0..7] (16 bits each) and pending flag P:
  - On acceptance, F[bin_index] <= bin_mag. A duplicate index within a frame is last-write-wins.
  - Accepting a bin with bin_last=1 sets P.
  - bin_ready = !P.
- Send bank S[0..7]. Swap occurs on the clk edge where P=1, the sender is in IDLE, and the state is not GAP:
  - S <= F, then F <= all zeros and P <= 0.
  - Bins not written in a frame are therefore sent as 16'h0000.
- Sender FSM states: IDLE, SETUP, HIGH, HOLD, GAP. Write index k runs 0..8.
  - IDLE: on swap, address <= 0, din <= F[0], k <= 0, go to SETUP.
  - SETUP: rcc_clk <= 1, go to HIGH.
  - HIGH: rcc_clk <= 0, go to HOLD. address and din stay stable through the falling edge.
  - HOLD, k<7: k <= k+1, address <= k+1, din <= S[k+1], go to SETUP.
  - HOLD, k=7: k <= 8, address <= ADDR_COMMIT, din <= 0, go to SETUP.
  - HOLD, k=8: gap counter <= GAP_CYCLES-1, go to GAP.
  - GAP: decrement the counter. When the counter is 0, go to IDLE.
- frame_count increments on the edge where the commit write enters HIGH.
- address and din retain their last values in GAP and IDLE.
- Reset (reset_n low, asynchronous, at any point including mid-frame or mid-write):
  - state IDLE, P=0, F=S=0, k=0, gap counter 0.
  - rcc_clk=0, address=4'h0, din=16'h0000, frame_count=8'h00.
  - busy=0, bin_ready=1 on release.
  - A partially sent frame is abandoned and never completed.
- Upstream may fill the next frame while the sender is in SETUP, HIGH, HOLD, or GAP. Once P is set, upstream stalls until the swap.

## Timing
- Define N as the cycle in which the bin_last bin is accepted, with the sender in IDLE.
  - P=1 in cycle N+1; swap on the edge ending N+1.
  - First rcc_clk high in cycle N+3. Write k is high in cycle N+3+3k; commit (k=8) is high in cycle N+27.
  - address and din become valid one cycle before each rcc_clk rise and are held one cycle after its fall.
  - rcc_clk high time is exactly 1 cycle; the write period is 3 cycles.
- Commit-to-commit minimum spacing is 28+GAP_CYCLES cycles when frames are back-to-back. Define C as the cycle in which the commit is high:
  - GAP covers cycles C+2 .. C+1+GAP_CYCLES.
  - IDLE (with swap if P) occurs at C+2+GAP_CYCLES.
- bin_ready drops in the cycle after bin_last is accepted. It rises in the cycle after the swap.
- A bin arriving in the same cycle the swap occurs is impossible, since bin_ready=0 while P=1.

## Test plan
- Reset with GAP_CYCLES=4 and one frame of mags 16'h0100+i, i=0..7, bin_last on i=7:
  - nine rcc_clk pulses;
  - at each falling edge address/din equal 0/0100 … 7/0107, then F/0000;
  - frame_count=1.
- Frame with only bins 2 and 5 written (2=16'hABCD, 5=16'h1234, 5 carries bin_last): writes 0..7 carry 0,0,ABCD,0,0,1234,0,0.
- Second frame fully delivered during the first frame's send: bin_ready=0 from P set until the swap; second commit rise exactly 28+GAP_CYCLES cycles after the first.
- Bin 3 written twice in a frame (16'h0011 then 16'h0022): address 3 sends 16'h0022.
- Assert reset_n mid-write, with rcc_clk high at k=4:
  - rcc_clk, address, din, and frame_count go to 0 immediately;
  - a fresh frame after release sends all nine writes from k=0.
- 256 back-to-back frames: frame_count wraps to 8'h00; there is no rcc_clk pulse during any GAP cycle.

Source files
------------

// File: rtl/rcc_frame_sched.sv
// rcc_frame_sched: double-buffers eight tone magnitudes per frame and replays them
// as nine strobed converter writes, then holds off for GAP_CYCLES before the next frame.
module rcc_frame_sched #(
  parameter int          GAP_CYCLES  = 128,
  parameter logic [3:0]  ADDR_COMMIT = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bin_valid,
  output logic        bin_ready,
  input  logic [2:0]  bin_index,
  input  logic [15:0] bin_mag,
  input  logic        bin_last,
  output logic        rcc_clk,
  output logic [3:0]  address,
  output logic [15:0] din,
  output logic        busy,
  output logic [7:0]  frame_count
);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [7:0][15:0] f, s;
  logic p, swap, accept;
  logic [3:0] k, k_n;
  logic [CW-1:0] cnt, cnt_n;
  logic rcc_clk_n;
  logic [3:0] address_n;
  logic [15:0] din_n;
  logic [7:0] frame_count_n;
  assign bin_ready = !p;
  assign accept = bin_valid && !p;
  assign swap = p && (state == IDLE);
  assign busy = (state != IDLE) || p;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      f <= '0;
      s <= '0;
      p <= 1'b0;
    end else if (swap) begin
      s <= f;
      f <= '0;
      p <= 1'b0;
    end else if (accept) begin
      f[bin_index] <= bin_mag;
      if (bin_last) p <= 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      rcc_clk     <= 1'b0;
      address     <= '0;
      din         <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      cnt         <= cnt_n;
      rcc_clk     <= rcc_clk_n;
      address     <= address_n;
      din         <= din_n;
      frame_count <= frame_count_n;
    end
  always_comb begin
    state_n       = state;
    k_n           = k;
    cnt_n         = cnt;
    rcc_clk_n     = rcc_clk;
    address_n     = address;
    din_n         = din;
    frame_count_n = frame_count;
    case (state)
      IDLE: if (swap) begin
        address_n = '0;
        din_n     = f[0];
        k_n       = '0;
        state_n   = SETUP;
      end
      SETUP: begin
        rcc_clk_n     = 1'b1;
        frame_count_n = (k == 4'd8) ? frame_count + 8'd1 : frame_count;
        state_n       = HIGH;
      end
      HIGH: begin
        rcc_clk_n = 1'b0;
        state_n   = HOLD;
      end
      HOLD: if (k == 4'd8) begin
        cnt_n   = CW'(GAP_CYCLES - 1);
        state_n = GAP;
      end else if (k == 4'd7) begin
        k_n       = 4'd8;
        address_n = ADDR_COMMIT;
        din_n     = '0;
        state_n   = SETUP;
      end else begin
        k_n       = k + 4'd1;
        address_n = k + 4'd1;
        din_n     = s[k[2:0] + 3'd1];
        state_n   = SETUP;
      end
      GAP: begin
        cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
        state_n = (cnt == '0) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
